// File: rtl/key_filter_pkg.sv
// Shared types and defaults for the multi-channel key filter.
// Build option KEY_FILTER_TOGGLE_EN is consumed in key_filter_ch.
package key_filter_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESS_FILT = 2'd1,
    DOWN       = 2'd2,
    REL_FILT   = 2'd3
  } key_state_e;

  // 20 ms debounce window at 50 MHz
  localparam int CNT_MAX_DEFAULT = 999_999;

endpackage

// File: rtl/key_filter_ch.sv
// One key channel: 2-FF synchroniser, debounce FSM with counter, press pulse, LED drive.
// KEY_FILTER_TOGGLE_EN defined: LED toggles per press; undefined: LED follows the held key.
module key_filter_ch
  import key_filter_pkg::*;
#(
  parameter int CNT_MAX = CNT_MAX_DEFAULT
) (
  input  logic sys_clk,
  input  logic sys_rest_n,
  input  logic key_in,
  output logic key_flag,
  output logic led_out
);

  localparam int CNT_W = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(CNT_MAX);

  logic [1:0]       sync_q;
  logic             key_s;
  key_state_e       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             flag_nxt;
  logic             led_nxt;

  assign key_s = sync_q[1];

  always_ff @(posedge sys_clk) begin
    if (!sys_rest_n) begin
      sync_q   <= 2'b11;
      state    <= IDLE;
      cnt      <= '0;
      key_flag <= 1'b0;
      led_out  <= 1'b0;
    end else begin
      sync_q   <= {sync_q[0], key_in};
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      key_flag <= flag_nxt;
      led_out  <= led_nxt;
    end
  end

  // Counter restarts from 0 on every state change and idles at 0 in the stable states
  always_comb begin
    state_nxt = state;
    cnt_nxt   = '0;
    flag_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (!key_s) state_nxt = PRESS_FILT;
      end
      PRESS_FILT: begin
        if (key_s) begin
          state_nxt = IDLE;
        end else if (cnt == CNT_TOP) begin
          state_nxt = DOWN;
          flag_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      DOWN: begin
        if (key_s) state_nxt = REL_FILT;
      end
      REL_FILT: begin
        if (!key_s) begin
          state_nxt = DOWN;
        end else if (cnt == CNT_TOP) begin
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
`ifdef KEY_FILTER_TOGGLE_EN
    led_nxt = led_out ^ flag_nxt;
`else
    led_nxt = (state_nxt == DOWN) || (state_nxt == REL_FILT);
`endif
  end

endmodule

// File: rtl/key_filter_multi.sv
// CH_NUM independent debounced active-low keys, each with a press pulse and LED output.
// LED mode selected per build by KEY_FILTER_TOGGLE_EN (see key_filter_ch).
module key_filter_multi
  import key_filter_pkg::*;
#(
  parameter int CH_NUM  = 4,
  parameter int CNT_MAX = CNT_MAX_DEFAULT
) (
  input  logic              sys_clk,
  input  logic              sys_rest_n,
  input  logic [CH_NUM-1:0] key_in,
  output logic [CH_NUM-1:0] key_flag,
  output logic [CH_NUM-1:0] led_out
);

  for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
    key_filter_ch #(
      .CNT_MAX(CNT_MAX)
    ) u_ch (
      .sys_clk   (sys_clk),
      .sys_rest_n(sys_rest_n),
      .key_in    (key_in[i]),
      .key_flag  (key_flag[i]),
      .led_out   (led_out[i])
    );
  end

endmodule

// File: doc/key_filter_multi.md
# key_filter_multi

Parametrised multi-channel key front end: synchronises, debounces and edge-detects CH_NUM active-low push-buttons and drives one registered LED output per channel. It replaces the single-bit registered key-to-LED path at the board I/O boundary, using the same sys_clk / sys_rest_n domain. It also provides a one-cycle press pulse per channel for downstream control logic.

## Interface
- CH_NUM, 4, number of independent key/LED channels (≥1)
- CNT_MAX, 999_999, debounce terminal count; 20 ms at 50 MHz (≥1)
- sys_clk  input  1  system clock, all logic on rising edge
- sys_rest_n  input  1  reset; one clock, synchronous, active-low
- key_in  input  CH_NUM  raw asynchronous keys, active-low (pressed = 0)
- key_flag  output  CH_NUM  one-cycle pulse per debounced press
- led_out  output  CH_NUM  registered LED drive, 1 = on

## Operation
- Per channel: 2-FF synchroniser → 4-state FSM + counter of width $clog2(CNT_MAX+1). Channels are fully independent.
- States: IDLE (stable released), PRESS_FILT, DOWN (stable pressed), REL_FILT.
- IDLE: sync = 0 → PRESS_FILT, cnt = 0.
- PRESS_FILT: sync = 1 → IDLE, cnt = 0, no flag (bounce). sync = 0 and cnt < CNT_MAX → cnt+1. sync = 0 and cnt == CNT_MAX → DOWN, cnt = 0, key_flag = 1 for that cycle.
- DOWN: sync = 1 → REL_FILT, cnt = 0.
- REL_FILT: sync = 0 → DOWN, cnt = 0. sync = 1 and cnt == CNT_MAX → IDLE, cnt = 0. Otherwise cnt+1. Release never raises key_flag.
- Counter never exceeds CNT_MAX. It holds 0 in IDLE and DOWN.
- Follow mode (default): led_out = 1 exactly while the state is DOWN or REL_FILT. It is registered and changes on the same edge as the state.
- Reset (sys_rest_n = 0 at an edge, including mid-filter) forces the following. The reset is not stretched.
  - sync regs = 1
  - state = IDLE
  - cnt = 0
  - key_flag = 0
  - led_out = 0

## Timing
- Press latency: key_in sampled low at edge k and held low. The synchroniser output is low after edge k+1. PRESS_FILT is entered at edge k+2, and key_flag rises after edge k+CNT_MAX+3 for exactly one cycle. Follow-mode led_out rises on the same edge.
- Release latency is symmetric: led_out falls CNT_MAX+3 edges after key_in is first sampled high.
- A glitch shorter than CNT_MAX+1 synchronised cycles produces no state change visible on the outputs.
- Held key: exactly one key_flag per press, regardless of hold time.
- Simultaneous presses on several channels flag on the same cycle if their timing is identical.

## Configuration
- Macro: KEY_FILTER_TOGGLE_EN.
- Defined: led_out inverts on every edge where key_flag is asserted. It holds its value through release and across presses, and reset clears it to 0.
- Undefined: follow mode as described above.
- key_flag behaviour is identical in both builds.

## Structure
- Shared package key_filter_pkg:
  - FSM state typedef: IDLE = 2'd0, PRESS_FILT = 2'd1, DOWN = 2'd2, REL_FILT = 2'd3
  - Default CNT_MAX constant: 20 ms at 50 MHz
- Sub-module key_filter_ch: one channel containing synchroniser, FSM, counter, key_flag and led_out. The top generates CH_NUM instances.
- The top module contains no other logic.

## Test plan
All scenarios use CNT_MAX = 9 and CH_NUM = 4.
- Reset with key_in = 4'b1111 for 3 cycles, then release: key_flag = 0, led_out = 0, no activity for 50 cycles.
- Channel 0 low at edge k, held 30 cycles: key_flag[0] is high only after edge k+12. Follow-mode led_out[0] rises at k+12 and falls 12 edges after key_in[0] returns high.
- Channel 1 bounce of 5-cycle low pulses separated by 2-cycle highs: no key_flag[1], led_out[1] = 0. A final 20-cycle low gives exactly one flag.
- All four channels pressed on the same edge: key_flag = 4'b1111 for one cycle at k+12.
- sys_rest_n asserted while channel 2 is at cnt = 6 in PRESS_FILT: all outputs 0 next cycle. After reset release with the key held low, key_flag[2] arrives a full 12 cycles later.
- KEY_FILTER_TOGGLE_EN defined, three separated presses on channel 3: led_out[3] goes 0 → 1 → 0 → 1, toggling on each key_flag edge.
